rl_ram_1r1w_init: RTL and testbench
===================================

RL_RAM_1R1W_INIT -- requirements
Module: rl_ram_1r1w_init

Interface
REQ-001 SHALL provide parameter ABITS, default 8, meaning address width; depth = 2**ABITS words.
REQ-002 SHALL provide parameter DBITS, default 8, meaning data width in bits (any value >= 1).
REQ-003 SHALL provide parameter REG_OUT, default 0, meaning 0 = one-cycle read latency, 1 = extra output register stage.
REQ-004 SHALL provide parameter INIT_VAL, default all-zero, DBITS wide, meaning word value written by the clear engine.
REQ-005 SHALL provide rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL provide clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL provide waddr  input  ABITS  write address.
REQ-008 SHALL provide din  input  DBITS  write data.
REQ-009 SHALL provide we  input  1  write enable.
REQ-010 SHALL provide be  input  (DBITS+7)/8  byte enables; be[k] covers bits 8k..8k+7, top byte partial when DBITS not a multiple of 8.
REQ-011 SHALL provide raddr  input  ABITS  read address.
REQ-012 SHALL provide re  input  1  read enable.
REQ-013 SHALL provide dout  output  DBITS  registered read data.
REQ-014 SHALL provide busy  output  1  high while the clear engine owns the array.

Function
REQ-015 SHALL implement a technology-independent behavioural array of 2**ABITS x DBITS with one write port and one read port on clk.
REQ-016 SHALL, when we=1 and busy=0, write din bits whose byte enable is 1 to waddr on the clock edge; bits with be=0 are unchanged.
REQ-017 SHALL, REG_OUT=0, present data of raddr on dout one cycle after a cycle with re=1 and busy=0.
REQ-018 SHALL, REG_OUT=1, present the same data two cycles after the re cycle; the second stage loads only when the first stage loaded.
REQ-019 SHALL hold dout unchanged in any cycle with no new read result.
REQ-020 SHALL implement clear FSM with states CLEAR and READY; CLEAR writes INIT_VAL to address counter cnt each cycle and increments cnt.
REQ-021 SHALL transition CLEAR -> READY on the cycle cnt = 2**ABITS-1 is written; cnt wraps to 0; clear takes exactly 2**ABITS cycles.
REQ-022 SHALL drive busy=1 in CLEAR and busy=0 in READY; READY is terminal until next reset.
REQ-023 SHALL ignore we and re while busy=1 (no user write, dout not updated).
REQ-024 SHALL, on same-cycle we=1 and re=1 with waddr=raddr and busy=0, return the behaviour defined by REQ-031/REQ-032.
REQ-025 SHALL treat simultaneous read and write to different addresses independently.

Reset
REQ-026 SHALL, on rstn=0, asynchronously force state CLEAR, cnt=0, busy=1, dout=0 and all output pipeline registers to 0.
REQ-027 SHALL not clear array contents asynchronously; contents are defined only after the clear engine completes.
REQ-028 SHALL, on reset asserted mid-clear, restart clearing from address 0 after rstn deasserts.
REQ-029 SHALL begin clearing on the first rising clk edge after rstn deasserts.

Configuration
REQ-030 SHALL use macro RL_RAM_1R1W_BYPASS_EN to select collision behaviour.
REQ-031 SHALL, with RL_RAM_1R1W_BYPASS_EN defined, forward din on collision: enabled bytes return new din, disabled bytes return stored data (write-first).
REQ-032 SHALL, without RL_RAM_1R1W_BYPASS_EN, return the stored data prior to the write on collision (read-first).

Verification (ABITS=4, DBITS=16, INIT_VAL=0)
REQ-033 SHALL check reset: release rstn -> busy=1 for exactly 16 cycles then 0; dout=0 throughout; read of every address afterwards returns 0x0000.
REQ-034 SHALL check byte enables: write 0xA5C3 be=2'b11 to addr 3, then 0xFF00 be=2'b01 to addr 3, read addr 3 -> 0xA500 (REG_OUT=0: one cycle after re; REG_OUT=1: two cycles).
REQ-035 SHALL check collision: addr 5 holds 0x1234, same-cycle write 0xABCD be=2'b10 and read addr 5 -> 0xAB34 with bypass macro, 0x1234 without.
REQ-036 SHALL check busy masking: we=1 din=0xFFFF addr 2 during CLEAR -> after busy=0 read addr 2 returns 0x0000; dout stays 0 for re during CLEAR.
REQ-037 SHALL check reset mid-clear: assert rstn=0 at cycle 7 of CLEAR, release -> busy=1 for a full 16 cycles again, dout=0.
REQ-038 SHALL check hold: read addr 3 (0xA500), then re=0 for 5 cycles with writes to addr 3 -> dout stays 0xA500.

Source files
------------

// File: rtl/rl_ram_1r1w_init.sv
// 1R1W behavioural RAM with byte enables and a self-clearing engine that fills every word with INIT_VAL after reset.
// Latency: read data on dout 1 cycle after re (REG_OUT=0) or 2 cycles (REG_OUT=1); clear takes 2**ABITS cycles.
// Backpressure: none on the user ports; busy=1 while clearing, and we/re are ignored then. Macro RL_RAM_1R1W_BYPASS_EN selects write-first collision data.
module rl_ram_1r1w_init #(
    parameter int               ABITS    = 8,
    parameter int               DBITS    = 8,
    parameter bit               REG_OUT  = 1'b0,
    parameter logic [DBITS-1:0] INIT_VAL = '0
) (
    input  logic                     rstn,
    input  logic                     clk,
    input  logic [ABITS-1:0]         waddr,
    input  logic [DBITS-1:0]         din,
    input  logic                     we,
    input  logic [(DBITS+7)/8-1:0]   be,
    input  logic [ABITS-1:0]         raddr,
    input  logic                     re,
    output logic [DBITS-1:0]         dout,
    output logic                     busy
);

    localparam int DEPTH = 2**ABITS;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ABITS-1:0]   cnt;
    logic [ABITS-1:0]   cnt_nxt;

    logic [DBITS-1:0]   mem [DEPTH];
    logic [DBITS-1:0]   bmask;
    logic [DBITS-1:0]   rd_dat;
    logic               rd_ld;

    logic [DBITS-1:0]   rd1_dat;
    logic               rd1_vld;
    logic [DBITS-1:0]   rd2_dat;

    // Expand byte enables to a per-bit mask; the top byte may be partial.
    for (genvar i = 0; i < DBITS; i++) begin : g_mask
        assign bmask[i] = be[i/8];
    end

    // Clear FSM state and address counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Clear FSM next state: sweep every address once, then stay READY until reset.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy    = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ABITS{1'b1}}) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                busy = 1'b0;
            end
            default: begin
                state_nxt = CLEAR;
                busy      = 1'b1;
            end
        endcase
    end

    // Array write port: clear engine has priority; user writes merge enabled bytes only.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= INIT_VAL;
        end else if (we) begin
            mem[waddr] <= (din & bmask) | (mem[waddr] & ~bmask);
        end
    end

    // Read data selection; on an address collision either forward new bytes or return old contents.
    always_comb begin
        rd_ld  = re & ~busy;
        rd_dat = mem[raddr];
`ifdef RL_RAM_1R1W_BYPASS_EN
        if (we && (waddr == raddr)) begin
            rd_dat = (din & bmask) | (mem[raddr] & ~bmask);
        end
`endif
    end

    // First output stage: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd1_dat <= '0;
            rd1_vld <= 1'b0;
        end else begin
            rd1_vld <= rd_ld;
            if (rd_ld) begin
                rd1_dat <= rd_dat;
            end
        end
    end

    // Optional second output stage: follows the first stage only when it loaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd2_dat <= '0;
        end else if (rd1_vld) begin
            rd2_dat <= rd1_dat;
        end
    end

    assign dout = REG_OUT ? rd2_dat : rd1_dat;

endmodule

// File: tb/tb_rl_ram_1r1w_init.sv
// Self-checking bench for rl_ram_1r1w_init: directed scenarios plus random traffic against a word-array model.
// Latency: model delays read results by 1 or 2 edges depending on REG_OUT.
// Backpressure: none; busy masking is modelled as dropped requests.
module tb_rl_ram_1r1w_init;

    localparam int          ABITS    = 4;
    localparam int          DBITS    = 16;
    localparam int          DEPTH    = 16;
    localparam bit          REG_OUT  = 1'b0;
    localparam logic [15:0] INIT_VAL = 16'h0000;

    logic        rstn;
    logic        clk;
    logic [3:0]  waddr;
    logic [15:0] din;
    logic        we;
    logic [1:0]  be;
    logic [3:0]  raddr;
    logic        re;
    logic [15:0] dout;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    logic [15:0] m_mem [DEPTH];
    int          m_clr;
    logic [15:0] m_dout;
    logic        m_v1;
    logic [15:0] m_p1;

    rl_ram_1r1w_init #(
        .ABITS   (ABITS),
        .DBITS   (DBITS),
        .REG_OUT (REG_OUT),
        .INIT_VAL(INIT_VAL)
    ) dut (
        .rstn (rstn),
        .clk  (clk),
        .waddr(waddr),
        .din  (din),
        .we   (we),
        .be   (be),
        .raddr(raddr),
        .re   (re),
        .dout (dout),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bytemask(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    // Apply the effect of one clock edge to the model using the inputs held across it.
    task automatic model_edge();
        logic [15:0] rd;
        logic [15:0] mk;
        logic        rv;
        rd = '0;
        rv = 1'b0;
        if (m_clr < DEPTH) begin
            m_clr++;
            if (m_clr == DEPTH) begin
                for (int a = 0; a < DEPTH; a++) m_mem[a] = INIT_VAL;
            end
        end else begin
            mk = bytemask(be);
            rv = re;
            rd = m_mem[raddr];
`ifdef RL_RAM_1R1W_BYPASS_EN
            if (we && (waddr == raddr)) rd = (din & mk) | (rd & ~mk);
`endif
            if (we) m_mem[waddr] = (din & mk) | (m_mem[waddr] & ~mk);
        end
        if (REG_OUT) begin
            if (m_v1) m_dout = m_p1;
            m_v1 = rv;
            if (rv) m_p1 = rd;
        end else if (rv) begin
            m_dout = rd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rstn) model_edge();
        chk("busy", busy, (m_clr < DEPTH));
        chk("dout", dout, m_dout);
    endtask

    task automatic idle();
        we = 1'b0;
        re = 1'b0;
    endtask

    // Assert reset asynchronously between edges, hold for two edges, release just after an edge.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        idle();
        m_clr  = 0;
        m_dout = '0;
        m_v1   = 1'b0;
        m_p1   = '0;
        #1;
        chk("rst_busy", busy, 1'b1);
        chk("rst_dout", dout, 16'h0);
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        idle();
        chk(tag, n, DEPTH);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        we = 1'b1; waddr = a; din = d; be = b; re = 1'b0;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        re = 1'b1; raddr = a; we = 1'b0;
        tick();
        re = 1'b0;
        repeat (REG_OUT) tick();
    endtask

    initial begin
        logic [15:0] exp_col;
        rstn = 1'b1; waddr = '0; din = '0; we = 1'b0; be = '0; raddr = '0; re = 1'b0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = 'x;
        #3;
        do_reset();

        // Clear with user traffic to addr 2 that must be ignored.
        we = 1'b1; waddr = 4'd2; din = 16'hFFFF; be = 2'b11;
        re = 1'b1; raddr = 4'd2;
        wait_clear("clear_len");

        for (int a = 0; a < DEPTH; a++) begin
            rd(a[3:0]);
            chk((a == 2) ? "busy_mask_wr" : "clr_val", dout, 16'h0000);
        end

        // Byte-enable merge.
        wr(4'd3, 16'hA5C3, 2'b11);
        wr(4'd3, 16'hFF00, 2'b01);
        rd(4'd3);
        chk("be_merge", dout, 16'hA500);

        // Hold while only writes occur.
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; waddr = 4'd3; din = 16'($urandom); be = 2'b11; re = 1'b0;
            tick();
            chk("hold", dout, 16'hA500);
        end
        idle();

        // Same-address read/write collision.
        wr(4'd5, 16'h1234, 2'b11);
        we = 1'b1; waddr = 4'd5; din = 16'hABCD; be = 2'b10;
        re = 1'b1; raddr = 4'd5;
        tick();
        idle();
        repeat (REG_OUT) tick();
`ifdef RL_RAM_1R1W_BYPASS_EN
        exp_col = 16'hAB34;
`else
        exp_col = 16'h1234;
`endif
        chk("collide", dout, exp_col);
        rd(4'd5);
        chk("collide_stored", dout, 16'hAB34);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we    = 1'($urandom);
            re    = 1'($urandom);
            waddr = 4'($urandom);
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
            din   = 16'($urandom);
            be    = 2'($urandom);
            tick();
        end
        idle();

        // Reset in the middle of a clear restarts the full sweep.
        do_reset();
        repeat (7) tick();
        do_reset();
        wait_clear("reclear_len");
        rd(4'd3);
        chk("reclear_val", dout, 16'h0000);
        rd(4'd5);
        chk("reclear_val5", dout, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
